// File: rtl/text_value_formatter.sv
// Binary-to-decimal text formatter feeding the overlay line buffer via double-dabble.
// Optional build macro TEXT_FMT_SIGNED_EN: two's complement input with a leading sign column.
module text_value_formatter #(
  parameter int unsigned VALUE_WIDTH = 16,
  parameter int unsigned NUM_DIGITS  = 5,
  parameter int unsigned NUM_CHAR    = 16,
  parameter int unsigned FIELD_POS   = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [VALUE_WIDTH-1:0]      i_value,
  input  logic                        i_value_valid,
  input  logic                        i_lbl_wr_en,
  input  logic [$clog2(NUM_CHAR)-1:0] i_lbl_addr,
  input  logic [7:0]                  i_lbl_data,
  input  logic                        i_wr_completed,
  output logic [NUM_CHAR-1:0][7:0]    o_characters,
  output logic                        o_wr_ready,
  output logic                        o_busy
);

  localparam int unsigned AddrW = $clog2(NUM_CHAR);
`ifdef TEXT_FMT_SIGNED_EN
  localparam int unsigned SignW = 1;
`else
  localparam int unsigned SignW = 0;
`endif
  localparam int unsigned FieldW     = NUM_DIGITS + SignW;
  // Decimal digits needed for 2^VALUE_WIDTH-1 (log10(2) ~= 0.30103).
  localparam int unsigned NeedDigits = (VALUE_WIDTH * 30103) / 100000 + 1;
  localparam int unsigned BcdDigits  = (NeedDigits > NUM_DIGITS) ? NeedDigits : NUM_DIGITS;
  localparam int unsigned BcdW       = 4 * BcdDigits;
  localparam int unsigned CntW       = $clog2(VALUE_WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(VALUE_WIDTH - 1);
  localparam int unsigned ByteLo     = NUM_CHAR - FIELD_POS - FieldW;

  // Larger than any magnitude; used as the saturated value of 10^n.
  localparam logic [VALUE_WIDTH:0] Sat = {1'b1, {VALUE_WIDTH{1'b0}}};

  function automatic logic [VALUE_WIDTH:0] pow10_sat(input int unsigned n);
    logic [VALUE_WIDTH+4:0] t;
    logic [VALUE_WIDTH:0]   r;
    r    = '0;
    r[0] = 1'b1;
    for (int unsigned i = 0; i < n; i++) begin
      t = ({4'b0, r} << 3) + ({4'b0, r} << 1);
      if (t >= {4'b0, Sat}) r = Sat;
      else                  r = t[VALUE_WIDTH:0];
    end
    return r;
  endfunction

  localparam logic [VALUE_WIDTH:0] OvfLimit = pow10_sat(NUM_DIGITS);

  typedef enum logic [2:0] {
    StIdle,
    StConvert,
    StFormat,
    StPublish,
    StWaitStart,
    StWaitDone
  } state_e;

  state_e                     state_q, state_d;
  logic [VALUE_WIDTH-1:0]     shift_q, shift_d;
  logic [BcdW-1:0]            bcd_q, bcd_d;
  logic [BcdW-1:0]            bcd_adj;
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic                       ovf_q, ovf_d;
  logic                       wr_ready_q, wr_ready_d;
  logic [NUM_CHAR-1:0][7:0]   chars_q, chars_d;
  logic [NUM_DIGITS-1:0][7:0] digit_chars;
  logic [VALUE_WIDTH-1:0]     magnitude;
`ifdef TEXT_FMT_SIGNED_EN
  logic                       neg;
  logic                       neg_q, neg_d;
`endif

`ifdef TEXT_FMT_SIGNED_EN
  // Most negative input negates to itself, which reads correctly as an unsigned magnitude.
  always_comb begin
    neg       = i_value[VALUE_WIDTH-1];
    magnitude = neg ? (~i_value + VALUE_WIDTH'(1)) : i_value;
  end
`else
  always_comb begin
    magnitude = i_value;
  end
`endif

  always_comb begin
    logic [3:0] nib;
    bcd_adj = '0;
    nib     = '0;
    for (int d = 0; d < int'(BcdDigits); d++) begin
      nib = bcd_q[4*d +: 4];
      bcd_adj[4*d +: 4] = (nib >= 4'd5) ? (nib + 4'd3) : nib;
    end
  end

  // Leading-zero blanking; the least significant digit is always drawn.
  always_comb begin
    logic       blank;
    logic [3:0] nib;
    digit_chars = '0;
    blank       = 1'b1;
    nib         = '0;
    for (int d = int'(NUM_DIGITS) - 1; d >= 0; d--) begin
      nib = bcd_q[4*d +: 4];
      if (ovf_q) begin
        digit_chars[d] = 8'h23;
      end else if (blank && (nib == 4'd0) && (d != 0)) begin
        digit_chars[d] = 8'h20;
      end else begin
        blank          = 1'b0;
        digit_chars[d] = {4'h3, nib};
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
`ifdef TEXT_FMT_SIGNED_EN
    neg_d      = neg_q;
`endif
    wr_ready_d = (state_q == StPublish);
    case (state_q)
      StIdle: begin
        if (i_value_valid) begin
          state_d = StConvert;
          shift_d = magnitude;
          bcd_d   = '0;
          cnt_d   = '0;
          ovf_d   = ({1'b0, magnitude} >= OvfLimit);
`ifdef TEXT_FMT_SIGNED_EN
          neg_d   = neg;
`endif
        end
      end
      StConvert: begin
        {bcd_d, shift_d} = {bcd_adj, shift_q} << 1;
        cnt_d            = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) state_d = StFormat;
      end
      StFormat:    state_d = StPublish;
      StPublish:   state_d = StWaitStart;
      StWaitStart: if (!i_wr_completed) state_d = StWaitDone;
      StWaitDone:  if (i_wr_completed) state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  always_comb begin
    chars_d = chars_q;
    if ((state_q == StIdle) && i_lbl_wr_en) begin
      // Decode by equality so addresses beyond the buffer match nothing.
      for (int p = 0; p < int'(NUM_CHAR); p++) begin
        if (i_lbl_addr == AddrW'(p)) chars_d[NUM_CHAR-1-p] = i_lbl_data;
      end
    end
    if (state_q == StFormat) begin
      for (int d = 0; d < int'(NUM_DIGITS); d++) begin
        chars_d[ByteLo + d] = digit_chars[d];
      end
`ifdef TEXT_FMT_SIGNED_EN
      chars_d[ByteLo + NUM_DIGITS] = neg_q ? 8'h2D : 8'h20;
`endif
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
`ifdef TEXT_FMT_SIGNED_EN
      neg_q      <= 1'b0;
`endif
      wr_ready_q <= 1'b0;
      chars_q    <= {NUM_CHAR{8'h20}};
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
`ifdef TEXT_FMT_SIGNED_EN
      neg_q      <= neg_d;
`endif
      wr_ready_q <= wr_ready_d;
      chars_q    <= chars_d;
    end
  end

  assign o_characters = chars_q;
  assign o_wr_ready   = wr_ready_q;
  assign o_busy       = (state_q != StIdle);

endmodule

// File: tb/tb_text_value_formatter.sv
// Directed bench for text_value_formatter: default instance plus a NUM_DIGITS=4 instance.
module tb_text_value_formatter;

`ifdef TEXT_FMT_SIGNED_EN
  localparam int FW  = 6;
  localparam int FW4 = 5;
  localparam logic [8*FW-1:0]  E_1234   = "  1234";
  localparam logic [8*FW-1:0]  E_0      = "     0";
  localparam logic [8*FW-1:0]  E_FFFF   = "-    1";
  localparam logic [8*FW-1:0]  E_42     = "    42";
  localparam logic [8*FW-1:0]  E_5      = "     5";
  localparam logic [8*FW4-1:0] E4_10000 = " ####";
  localparam logic [8*FW4-1:0] E4_9999  = " 9999";
`else
  localparam int FW  = 5;
  localparam int FW4 = 4;
  localparam logic [8*FW-1:0]  E_1234   = " 1234";
  localparam logic [8*FW-1:0]  E_0      = "    0";
  localparam logic [8*FW-1:0]  E_FFFF   = "65535";
  localparam logic [8*FW-1:0]  E_42     = "   42";
  localparam logic [8*FW-1:0]  E_5      = "    5";
  localparam logic [8*FW4-1:0] E4_10000 = "####";
  localparam logic [8*FW4-1:0] E4_9999  = "9999";
`endif

  logic             clk;
  logic             rst;
  logic [15:0]      value;
  logic             valid;
  logic             lbl_en;
  logic [3:0]       lbl_addr;
  logic [7:0]       lbl_data;
  logic             completed;
  logic [15:0][7:0] chars;
  logic             wr_ready;
  logic             busy;

  logic [15:0]      value4;
  logic             valid4;
  logic             completed4;
  logic [15:0][7:0] chars4;
  logic             wr_ready4;
  logic             busy4;

  int total;
  int bad;
  int dn_cnt;
  int dn_cnt4;

  text_value_formatter u_dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_value        (value),
    .i_value_valid  (valid),
    .i_lbl_wr_en    (lbl_en),
    .i_lbl_addr     (lbl_addr),
    .i_lbl_data     (lbl_data),
    .i_wr_completed (completed),
    .o_characters   (chars),
    .o_wr_ready     (wr_ready),
    .o_busy         (busy)
  );

  text_value_formatter #(
    .NUM_DIGITS (4)
  ) u_dut4 (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_value        (value4),
    .i_value_valid  (valid4),
    .i_lbl_wr_en    (1'b0),
    .i_lbl_addr     (4'd0),
    .i_lbl_data     (8'h00),
    .i_wr_completed (completed4),
    .o_characters   (chars4),
    .o_wr_ready     (wr_ready4),
    .o_busy         (busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Overlay model: drop completed the cycle after the pulse, raise it 17 cycles later.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      completed <= 1'b1;
      dn_cnt    <= 0;
    end else if (wr_ready) begin
      completed <= 1'b0;
      dn_cnt    <= 17;
    end else if (dn_cnt != 0) begin
      dn_cnt <= dn_cnt - 1;
      if (dn_cnt == 1) completed <= 1'b1;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      completed4 <= 1'b1;
      dn_cnt4    <= 0;
    end else if (wr_ready4) begin
      completed4 <= 1'b0;
      dn_cnt4    <= 17;
    end else if (dn_cnt4 != 0) begin
      dn_cnt4 <= dn_cnt4 - 1;
      if (dn_cnt4 == 1) completed4 <= 1'b1;
    end
  end

  // Call just after a negedge. i counts negedges after the accepting edge.
  task automatic send_value(input logic [15:0] v, input int lbl_at, input bit inject,
                            output int pulse_at, output int npulse, output int done_at,
                            output logic [8*FW-1:0] field17);
    bit injected;
    injected = 1'b0;
    pulse_at = -1;
    npulse   = 0;
    done_at  = -1;
    field17  = '0;
    value    = v;
    valid    = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      valid  = 1'b0;
      lbl_en = 1'b0;
      if (i == lbl_at) begin
        lbl_en   = 1'b1;
        lbl_addr = 4'd1;
        lbl_data = 8'h58;
      end
      if (inject && !injected && (i > 20) && !completed && busy) begin
        value    = 16'd999;
        valid    = 1'b1;
        injected = 1'b1;
      end
      if (wr_ready) begin
        npulse++;
        if (pulse_at < 0) pulse_at = i;
      end
      if (i == 17) field17 = chars[7 -: FW];
      if (!busy) begin
        done_at = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (chars !== {16{8'h20}}) begin
      bad++; $display("FAIL reset_chars: got %h want all 20", chars);
    end
    total++;
    if (wr_ready !== 1'b0) begin
      bad++; $display("FAIL reset_wr_ready: got %b want 0", wr_ready);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL reset_busy: got %b want 0", busy);
    end
    total++;
    if (chars4 !== {16{8'h20}} || busy4 !== 1'b0 || wr_ready4 !== 1'b0) begin
      bad++; $display("FAIL reset_nd4: got %h/%b/%b want all 20/0/0", chars4, busy4, wr_ready4);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_value_1234;
    int pa, np, da;
    logic [8*FW-1:0] f17;
    send_value(16'd1234, -1, 1'b0, pa, np, da, f17);
    total++;
    if (pa != 18) begin
      bad++; $display("FAIL v1234_pulse_time: got %0d want 18", pa);
    end
    total++;
    if (np != 1) begin
      bad++; $display("FAIL v1234_pulse_count: got %0d want 1", np);
    end
    total++;
    if (f17 !== E_1234) begin
      bad++; $display("FAIL v1234_field_early: got %h want %h", f17, E_1234);
    end
    total++;
    if (da != 37) begin
      bad++; $display("FAIL v1234_busy_fall: got %0d want 37", da);
    end
    total++;
    if (chars[7 -: FW] !== E_1234) begin
      bad++; $display("FAIL v1234_field_idle: got %h want %h", chars[7 -: FW], E_1234);
    end
  endtask

  task automatic test_zero_max;
    int pa, np, da;
    logic [8*FW-1:0] f17;
    send_value(16'd0, -1, 1'b0, pa, np, da, f17);
    total++;
    if (chars[7 -: FW] !== E_0 || da != 37) begin
      bad++; $display("FAIL zero_field: got %h/%0d want %h/37", chars[7 -: FW], da, E_0);
    end
    // Next value presented on the first idle cycle.
    send_value(16'hFFFF, -1, 1'b0, pa, np, da, f17);
    total++;
    if (chars[7 -: FW] !== E_FFFF) begin
      bad++; $display("FAIL max_field: got %h want %h", chars[7 -: FW], E_FFFF);
    end
    total++;
    if (pa != 18 || np != 1) begin
      bad++; $display("FAIL max_pulse: got %0d/%0d want 18/1", pa, np);
    end
    total++;
    if (chars[15:8] !== {8{8'h20}} || chars[7-FW:0] !== {(8-FW){8'h20}}) begin
      bad++; $display("FAIL max_outside_field: got %h want spaces outside field", chars);
    end
  endtask

  task automatic test_overflow;
    int t;
    value4 = 16'd10000;
    valid4 = 1'b1;
    @(negedge clk);
    valid4 = 1'b0;
    t = 0;
    while (busy4 && t < 200) begin
      @(negedge clk);
      t++;
    end
    total++;
    if (busy4 || t != 37) begin
      bad++; $display("FAIL ovf_done: got busy=%b t=%0d want busy=0 t=37", busy4, t);
    end
    total++;
    if (chars4[7 -: FW4] !== E4_10000) begin
      bad++; $display("FAIL ovf_10000: got %h want %h", chars4[7 -: FW4], E4_10000);
    end
    value4 = 16'd9999;
    valid4 = 1'b1;
    @(negedge clk);
    valid4 = 1'b0;
    t = 0;
    while (busy4 && t < 200) begin
      @(negedge clk);
      t++;
    end
    total++;
    if (busy4 || chars4[7 -: FW4] !== E4_9999) begin
      bad++; $display("FAIL ovf_9999: got %h busy=%b want %h", chars4[7 -: FW4], busy4, E4_9999);
    end
  endtask

  task automatic test_label;
    int pa, np, da;
    logic [8*FW-1:0] f17;
    lbl_en   = 1'b1;
    lbl_addr = 4'd0;
    lbl_data = 8'h54;
    send_value(16'd42, 3, 1'b0, pa, np, da, f17);
    total++;
    if (chars[15] !== 8'h54) begin
      bad++; $display("FAIL label_idle_write: got %h want 54", chars[15]);
    end
    total++;
    if (chars[14] !== 8'h20) begin
      bad++; $display("FAIL label_busy_ignored: got %h want 20", chars[14]);
    end
    total++;
    if (chars[7 -: FW] !== E_42 || np != 1 || pa != 18) begin
      bad++; $display("FAIL label_conversion: got %h/%0d/%0d want %h/1/18",
                      chars[7 -: FW], np, pa, E_42);
    end
  endtask

  task automatic test_reset_mid;
    int np;
    bit went_busy;
    value = 16'd777;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (busy !== 1'b0 || chars !== {16{8'h20}}) begin
      bad++; $display("FAIL reset_mid_state: got busy=%b chars=%h want 0/all 20", busy, chars);
    end
    np = 0;
    went_busy = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (wr_ready) np++;
      if (busy) went_busy = 1'b1;
    end
    total++;
    if (np != 0 || went_busy) begin
      bad++; $display("FAIL reset_mid_no_pulse: got pulses=%0d busy=%b want 0/0", np, went_busy);
    end
  endtask

  task automatic test_drop;
    int pa, np, da, extra;
    bit went_busy;
    logic [8*FW-1:0] f17;
    lbl_en   = 1'b1;
    lbl_addr = 4'd9;
    lbl_data = 8'h51;
    @(negedge clk);
    lbl_en = 1'b0;
    total++;
    if (chars[6] !== 8'h51) begin
      bad++; $display("FAIL label_field_pos: got %h want 51", chars[6]);
    end
    send_value(16'd5, -1, 1'b1, pa, np, da, f17);
    extra = 0;
    went_busy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (wr_ready) extra++;
      if (busy) went_busy = 1'b1;
    end
    total++;
    if (np != 1 || extra != 0) begin
      bad++; $display("FAIL drop_one_publish: got %0d+%0d want 1+0", np, extra);
    end
    total++;
    if (went_busy || da != 37) begin
      bad++; $display("FAIL drop_no_queue: got busy=%b done=%0d want 0/37", went_busy, da);
    end
    total++;
    if (chars[7 -: FW] !== E_5) begin
      bad++; $display("FAIL drop_field: got %h want %h", chars[7 -: FW], E_5);
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    value    = '0;
    valid    = 1'b0;
    lbl_en   = 1'b0;
    lbl_addr = '0;
    lbl_data = '0;
    value4   = '0;
    valid4   = 1'b0;
    test_reset();
    test_value_1234();
    test_zero_max();
    test_overflow();
    test_label();
    test_reset_mid();
    test_drop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/text_value_formatter.md
# text_value_formatter

Converts a binary value into right-justified decimal ASCII inside a fixed-width character line buffer. Publishes that buffer to the downstream text overlay stage with its write-ready / write-completed handshake. Sits directly upstream of the overlay: `o_characters` drives its `i_characters`, `o_wr_ready` drives its `i_wr_ready`, and its `o_wr_completed` returns on `i_wr_completed`. Static label text can be loaded into the rest of the buffer while the block is idle.

## Interface
- `VALUE_WIDTH`, 16: width of `i_value`.
- `NUM_DIGITS`, 5: decimal digit positions in the numeric field.
- `NUM_CHAR`, 16: characters in the line buffer; must equal the overlay's `NUM_CHAR`.
- `FIELD_POS`, 8: screen position of the field's leftmost character. Requires FIELD_POS + field width <= NUM_CHAR.
- `i_clk`, in, 1: clock.
- `i_rst`, in, 1: asynchronous, active-high reset.
- `i_value`, in, VALUE_WIDTH: value to display.
- `i_value_valid`, in, 1: value strobe; sampled only in IDLE.
- `i_lbl_wr_en`, in, 1: label character write; sampled only in IDLE.
- `i_lbl_addr`, in, $clog2(NUM_CHAR): screen position of the label write.
- `i_lbl_data`, in, 8: ASCII code for the label write.
- `i_wr_completed`, in, 1: downstream idle/done level.
- `o_characters`, out, [NUM_CHAR-1:0][7:0]: line buffer. Screen position p is carried in byte NUM_CHAR-1-p.
- `o_wr_ready`, out, 1: one-cycle publish pulse.
- `o_busy`, out, 1: high in every state except IDLE.

## Operation
- States and transitions:
  - IDLE -> CONVERT when `i_value_valid` is high.
  - CONVERT -> FORMAT after exactly VALUE_WIDTH cycles.
  - FORMAT -> PUBLISH.
  - PUBLISH -> WAIT_START.
  - WAIT_START -> WAIT_DONE when `i_wr_completed` is low.
  - WAIT_DONE -> IDLE when `i_wr_completed` is high.
- IDLE accept:
  - Capture `i_value`.
  - Compute overflow as magnitude > 10^NUM_DIGITS − 1.
  - Clear the BCD register.
- CONVERT: double-dabble, one bit per cycle, MSB first. In each cycle, add 3 to every BCD nibble >= 5, then shift left by one.
- FORMAT: write the field in one cycle.
  - Right-justified.
  - Leading zeros become 0x20.
  - Value 0 renders as a single '0' (0x30) in the last position.
  - On overflow, every digit position becomes '#' (0x23).
- Buffer bytes outside the field change only through label writes.
- Label writes:
  - Accepted in IDLE only; ignored in any other state.
  - A label write to a field position is overwritten at the next FORMAT.
  - `i_lbl_addr` >= NUM_CHAR is ignored.
- A label write and `i_value_valid` in the same IDLE cycle: both take effect.
- `i_value_valid` while `o_busy` is high: dropped, no queueing.
- `o_characters` is stable from FORMAT until the return to IDLE.

## Timing
- Reset values:
  - All `o_characters` bytes = 0x20.
  - `o_wr_ready` = 0.
  - `o_busy` = 0.
  - State = IDLE.
- Reset mid-operation returns to IDLE immediately and discards the conversion.
- Value accepted on edge N:
  - `o_busy` high from N+1.
  - Field bytes valid after edge N+VALUE_WIDTH+1.
  - `o_wr_ready` high for exactly the cycle after edge N+VALUE_WIDTH+2.
- The downstream stage drops `i_wr_completed` one cycle after the pulse. WAIT_START tolerates any delay.
- `o_busy` falls on the edge after `i_wr_completed` is sampled high in WAIT_DONE. The earliest next accept is on that edge's following cycle.

## Configuration
- `TEXT_FMT_SIGNED_EN` defined:
  - `i_value` is two's complement.
  - Field width is NUM_DIGITS+1; position FIELD_POS holds the sign: '-' (0x2D) if negative, otherwise 0x20.
  - Digits are the magnitude; the most negative value is handled as an unsigned magnitude.
  - Overflow still shows '-' for negative values.
  - CONVERT is unchanged at VALUE_WIDTH cycles.
- Undefined: `i_value` is unsigned, and the field width is NUM_DIGITS.

## Test plan
All scenarios use default parameters unless stated, with a downstream model that drops `i_wr_completed` 1 cycle after the pulse and raises it 17 cycles later.

- Reset: assert `i_rst` -> all 16 bytes = 0x20, `o_wr_ready` = 0, `o_busy` = 0.
- Value 1234 -> positions 8..12 = 20 31 32 33 34; `o_wr_ready` pulses exactly 18 cycles after accept; `o_busy` falls after `i_wr_completed` returns high.
- Value 0, then value 65535 -> field "    0", then "65535"; the second value is presented only after `o_busy` falls.
- NUM_DIGITS=4, value 10000 -> "####"; with `TEXT_FMT_SIGNED_EN` defined, value 0xFFFF -> positions 8..13 = "-    1".
- Label write 'T' to address 0 in IDLE plus a simultaneous `i_value_valid` -> byte 15 = 0x54 and the conversion proceeds; a label write while busy -> ignored.
- Assert `i_rst` during CONVERT cycle 5 -> IDLE and all spaces with no pulse; a second `i_value_valid` during WAIT_DONE -> dropped, with exactly one publish.
